trng_health_monitor: RTL
========================

Name: trng_health_monitor

Overview:
Online entropy health test stage. It sits between the Von Neumann unbiaser wrapper and the entropy vector buffer, and is gated by the BIST-enable input pin. It runs a repetition count test (RCT) and an adaptive proportion test (APT) on the unbiased bit stream. It forwards only bits that pass the startup and continuous tests, and latches a sticky alarm on failure. Its 2-bit state drives the wrapper_state field on uio_out.

Parameters:
RCT_CUTOFF, 16, number of identical consecutive valid bits that fails the RCT.
APT_WINDOW, 64, number of valid bits per APT window (power of two, >= 8).
APT_CUTOFF, 48, number of matches to the window's reference bit that fails the APT (< APT_WINDOW).
STARTUP_BITS, 64, valid bits that must be tested without failure before forwarding starts.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
bist_en  in  1  1 = tests active; 0 = bypass (registered pass-through, tests cleared)
clr_alarm  in  1  single-cycle pulse; leaves ALARM and restarts startup
in_valid  in  1  input bit qualifier from the unbiaser
in_bit  in  1  unbiased random bit
out_valid  out  1  output bit qualifier to the vector buffer
out_bit  out  1  forwarded random bit
rct_fail  out  1  sticky RCT failure flag
apt_fail  out  1  sticky APT failure flag
state  out  2  00 IDLE, 01 STARTUP, 10 RUN, 11 ALARM

Behaviour:
- Reset (async assert, sync deassert on clk): state=IDLE, out_valid=0, out_bit=0, rct_fail=0, apt_fail=0. All counters are 0 and have_last=0.
- All outputs are registered. Forwarding latency is 1 cycle from in_valid to out_valid.
- IDLE: out_valid <= in_valid and out_bit <= in_bit (bypass). Counters are held at 0. bist_en=1 moves to STARTUP on the next edge; the bit sampled on that edge is bypassed.
- STARTUP: tests run on every valid bit and out_valid=0.
  - After STARTUP_BITS valid bits with no failure, move to RUN. Transition on the edge that accepts the last startup bit; that bit is not forwarded.
- RUN: a valid bit that does not trigger a failure is forwarded. A bit that triggers a failure is not forwarded.
- ALARM: out_valid=0 and input is ignored. The state is left only by clr_alarm (to STARTUP, flags cleared), bist_en=0 (to IDLE, flags cleared) or reset.
- Any failure in STARTUP or RUN moves to ALARM on the same edge that accepts the failing bit, and sets the corresponding sticky flag(s). Both flags may set on the same bit.
- RCT, per valid bit:
  - If have_last and in_bit==last, run = run+1; otherwise run=1, last=in_bit, have_last=1.
  - Fail when the updated run equals RCT_CUTOFF.
  - Counter width is clog2(RCT_CUTOFF+1); the counter saturates and never wraps.
- APT, per valid bit:
  - Sample index 0 of a window latches ref=in_bit and sets match=1.
  - Later samples increment match when in_bit==ref.
  - Fail when the updated match equals APT_CUTOFF.
  - The sample index wraps from APT_WINDOW-1 to 0; the next valid bit starts a new window.
- Counter reset: counters and have_last clear on entry to IDLE and on entry to STARTUP. They do not clear on the STARTUP to RUN transition; tests are continuous.
- Priority on one edge: rst_n, then bist_en=0, then clr_alarm, then failure evaluation.
  - clr_alarm in any non-IDLE state forces STARTUP with counters cleared. The bit on that edge is discarded and not evaluated.
- A bist_en deassert mid-window goes to IDLE the next edge and discards the partial window.
- in_valid=0 cycles change nothing except out_valid <= 0.

Decomposition:
- Package trng_health_pkg holds:
  - the state enum (IDLE/STARTUP/RUN/ALARM with the encodings above);
  - the default cutoff constants;
  - a clog2-based width helper.
- One natural sub-module, trng_apt_window: window index, reference bit and match counter. Inputs: clear, valid, bit. Output: fail.
- The RCT and the FSM live in the top of the block.

Test Plan:
1. bist_en=0, feed 10101100 with in_valid every cycle -> out_bit replays the same sequence 1 cycle later, state=00, flags stay 0.
2. bist_en=1, feed alternating 0101... -> state 01 and out_valid=0 for 64 valid bits. state=10 after the 64th; bit 65 appears on out_bit 1 cycle later.
3. In RUN, feed 16 consecutive 1s -> first 15 forwarded, 16th not. rct_fail=1, state=11, apt_fail=0, and later bits never produce out_valid.
4. In STARTUP, feed "0001" repeated (max run 3) -> apt_fail=1 on window sample 62 (the 48th zero), state=11, rct_fail=0. Pattern "0011" repeated for 256 bits -> no failure.
5. In ALARM, pulse clr_alarm -> flags 0, state=01, and 64 new clean bits are required before out_valid. A clr_alarm pulse coincident with the would-be 16th repeated bit -> no flag set, state=01.
6. Assert rst_n=0 between edges during RUN -> out_valid, flags and state are 0 immediately. bist_en held 1 -> state=01 on the first edge after release.

Source files
------------

// File: rtl/trng_health_pkg.sv
// Shared types and constants for the TRNG online health monitor.
// State encoding matches the wrapper_state field it drives.
package trng_health_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        STARTUP = 2'b01,
        RUN     = 2'b10,
        ALARM   = 2'b11
    } hm_state_e;

    localparam int RCT_CUTOFF_DEF   = 16;
    localparam int APT_WINDOW_DEF   = 64;
    localparam int APT_CUTOFF_DEF   = 48;
    localparam int STARTUP_BITS_DEF = 64;

    // Bits needed to hold any count from 0 up to max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/trng_apt_window.sv
// Adaptive proportion test: per-window reference bit and match counter.
// fail is combinational on the bit being accepted this cycle.
module trng_apt_window
    import trng_health_pkg::*;
#(
    parameter int APT_WINDOW = APT_WINDOW_DEF,
    parameter int APT_CUTOFF = APT_CUTOFF_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic valid,
    input  logic in_bit,
    output logic fail
);

    localparam int IW = $clog2(APT_WINDOW);
    localparam int MW = cnt_width(APT_WINDOW);
    localparam logic [IW-1:0] IDX_LAST = IW'(APT_WINDOW - 1);
    localparam logic [MW-1:0] M_MAX    = MW'(APT_WINDOW);
    localparam logic [MW-1:0] M_CUT    = MW'(APT_CUTOFF);

    logic [IW-1:0] idx_q;
    logic [MW-1:0] match_q;
    logic [MW-1:0] match_upd;
    logic          ref_q;
    logic          first;

    // Updated match count for the bit presented this cycle.
    always_comb begin
        first     = (idx_q == '0);
        match_upd = match_q;
        if (first) begin
            match_upd = MW'(1);
        end else if (in_bit == ref_q && match_q != M_MAX) begin
            match_upd = match_q + 1'b1;
        end
        fail = valid && (match_upd == M_CUT);
    end

    // Window index, reference bit and match counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            match_q <= '0;
            ref_q   <= 1'b0;
        end else if (clear) begin
            idx_q   <= '0;
            match_q <= '0;
            ref_q   <= 1'b0;
        end else if (valid) begin
            idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            match_q <= match_upd;
            if (first) begin
                ref_q <= in_bit;
            end
        end
    end

endmodule

// File: rtl/trng_health_monitor.sv
// Online entropy health monitor: repetition count and adaptive proportion
// tests gate forwarding of unbiased bits; failures latch a sticky alarm.
module trng_health_monitor
    import trng_health_pkg::*;
#(
    parameter int RCT_CUTOFF   = RCT_CUTOFF_DEF,
    parameter int APT_WINDOW   = APT_WINDOW_DEF,
    parameter int APT_CUTOFF   = APT_CUTOFF_DEF,
    parameter int STARTUP_BITS = STARTUP_BITS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bist_en,
    input  logic       clr_alarm,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       out_valid,
    output logic       out_bit,
    output logic       rct_fail,
    output logic       apt_fail,
    output logic [1:0] state
);

    localparam int RW = cnt_width(RCT_CUTOFF);
    localparam int SW = cnt_width(STARTUP_BITS);
    localparam logic [RW-1:0] RCT_MAX = RW'(RCT_CUTOFF);
    localparam logic [SW-1:0] SU_LAST = SW'(STARTUP_BITS - 1);

    hm_state_e cur, nxt;

    logic [RW-1:0] run_q;
    logic [RW-1:0] run_upd;
    logic          last_q;
    logic          have_last_q;
    logic [SW-1:0] su_q;

    logic testing;
    logic clear;
    logic rct_now;
    logic apt_now;
    logic any_fail;

    logic out_valid_d;
    logic out_bit_d;
    logic rct_d;
    logic apt_d;

    // A bit is tested only in STARTUP/RUN when no override is active.
    always_comb begin
        testing = in_valid && bist_en && !clr_alarm
                  && (cur == STARTUP || cur == RUN);
        clear   = !bist_en || cur == IDLE
                  || (clr_alarm && cur != IDLE);
        run_upd = RW'(1);
        if (have_last_q && in_bit == last_q) begin
            run_upd = (run_q == RCT_MAX) ? run_q : run_q + 1'b1;
        end
        rct_now  = testing && (run_upd == RCT_MAX);
        any_fail = rct_now || apt_now;
    end

    trng_apt_window #(
        .APT_WINDOW(APT_WINDOW),
        .APT_CUTOFF(APT_CUTOFF)
    ) u_apt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .valid (testing),
        .in_bit(in_bit),
        .fail  (apt_now)
    );

    // Repetition count and startup bit counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q       <= '0;
            last_q      <= 1'b0;
            have_last_q <= 1'b0;
            su_q        <= '0;
        end else if (clear) begin
            run_q       <= '0;
            last_q      <= 1'b0;
            have_last_q <= 1'b0;
            su_q        <= '0;
        end else if (testing) begin
            run_q       <= run_upd;
            last_q      <= in_bit;
            have_last_q <= 1'b1;
            if (cur == STARTUP && !any_fail) begin
                su_q <= su_q + 1'b1;
            end
        end
    end

    // State and registered output updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= IDLE;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            rct_fail  <= 1'b0;
            apt_fail  <= 1'b0;
        end else begin
            cur       <= nxt;
            out_valid <= out_valid_d;
            out_bit   <= out_bit_d;
            rct_fail  <= rct_d;
            apt_fail  <= apt_d;
        end
    end

    // Next state, forwarding decision and sticky flag updates.
    always_comb begin
        nxt         = cur;
        out_valid_d = 1'b0;
        out_bit_d   = out_bit;
        rct_d       = rct_fail;
        apt_d       = apt_fail;
        unique case (cur)
            IDLE: begin
                out_valid_d = in_valid;
                out_bit_d   = in_bit;
                rct_d       = 1'b0;
                apt_d       = 1'b0;
                if (bist_en) begin
                    nxt = STARTUP;
                end
            end
            STARTUP, RUN, ALARM: begin
                if (!bist_en) begin
                    nxt   = IDLE;
                    rct_d = 1'b0;
                    apt_d = 1'b0;
                end else if (clr_alarm) begin
                    nxt   = STARTUP;
                    rct_d = 1'b0;
                    apt_d = 1'b0;
                end else if (any_fail) begin
                    nxt   = ALARM;
                    rct_d = rct_fail | rct_now;
                    apt_d = apt_fail | apt_now;
                end else if (testing) begin
                    if (cur == STARTUP && su_q == SU_LAST) begin
                        nxt = RUN;
                    end
                    if (cur == RUN) begin
                        out_valid_d = 1'b1;
                        out_bit_d   = in_bit;
                    end
                end
            end
            default: nxt = IDLE;
        endcase
    end

    assign state = cur;

endmodule
